// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and default sizes for the round-robin memory bus arbiter.
// Imported by the interface, the priority picker and the top.
package arb_pkg;

    localparam int DEFAULT_PROCS    = 4;
    localparam int DEFAULT_WORD     = 32;
    localparam int DEFAULT_ADDR_W   = 10;
    localparam int DEFAULT_MAX_HOLD = 16;

    localparam int GRANT_IDX_W = $clog2(DEFAULT_PROCS);
    localparam int HOLD_CNT_W  = $clog2(DEFAULT_MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Processor/memory side bundle of the arbiter.
// master = arbiter view, slave = processors plus memory view.
interface memory_bus_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUMBER_OF_PROCESSORS = DEFAULT_PROCS,
    parameter int WORD_SIZE            = DEFAULT_WORD,
    parameter int ADDRESS_WIDTH        = DEFAULT_ADDR_W
);
    localparam int N  = NUMBER_OF_PROCESSORS;
    localparam int DW = WORD_SIZE;
    localparam int AW = ADDRESS_WIDTH;

    logic [N-1:0]    i_Requests;
    logic [N-1:0]    o_Grants;
    logic [N*AW-1:0] i_Proc_Address;
    logic [N*DW-1:0] i_Proc_Write_Data;
    logic [N-1:0]    i_Proc_Read_Enable;
    logic [N-1:0]    i_Proc_Write_Enable;
    logic [DW-1:0]   o_Proc_Read_Data;
    logic [AW-1:0]   o_Memory_Address;
    logic [DW-1:0]   o_Memory_Write_Data;
    logic            o_Memory_Read_Enable;
    logic            o_Memory_Write_Enable;
    logic [DW-1:0]   i_Memory_Read_Data;
    logic            o_Busy;

    modport master (
        input  i_Requests, i_Proc_Address, i_Proc_Write_Data,
        input  i_Proc_Read_Enable, i_Proc_Write_Enable, i_Memory_Read_Data,
        output o_Grants, o_Proc_Read_Data, o_Memory_Address,
        output o_Memory_Write_Data, o_Memory_Read_Enable,
        output o_Memory_Write_Enable, o_Busy
    );

    modport slave (
        output i_Requests, i_Proc_Address, i_Proc_Write_Data,
        output i_Proc_Read_Enable, i_Proc_Write_Enable, i_Memory_Read_Data,
        input  o_Grants, o_Proc_Read_Data, o_Memory_Address,
        input  o_Memory_Write_Data, o_Memory_Read_Enable,
        input  o_Memory_Write_Enable, o_Busy
    );

endinterface

// File: rtl/memory_bus_arbiter_picker.sv
// Combinational round-robin pick: first set request at or after the
// pointer, wrapping modulo N.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);
    localparam logic [IW:0] NW = (IW + 1)'(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    always_comb begin
        rot     = N'({i_req, i_req} >> i_ptr);
        o_valid = 1'b0;
        off     = '0;
        // Scan downwards so the lowest rotated offset wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                o_valid = 1'b1;
                off     = IW'(i);
            end
        end
        sum = {1'b0, i_ptr} + {1'b0, off};
        if (sum >= NW) sum = sum - NW;
        o_idx = sum[IW-1:0];
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter muxing N processors onto one memory port.
// Define ARB_HOLD_TIMEOUT_EN to revoke grants held MAX_HOLD cycles under contention.
module memory_bus_arbiter
    import arb_pkg::*;
#(
    parameter int NUMBER_OF_PROCESSORS = DEFAULT_PROCS,
    parameter int WORD_SIZE            = DEFAULT_WORD,
    parameter int ADDRESS_WIDTH        = DEFAULT_ADDR_W,
    parameter int MAX_HOLD             = DEFAULT_MAX_HOLD
) (
    input logic clk,
    input logic reset,
    memory_bus_arbiter_if.master bus
);
    localparam int N  = NUMBER_OF_PROCESSORS;
    localparam int DW = WORD_SIZE;
    localparam int AW = ADDRESS_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  grants_q, grants_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          hold_expired;

    rr_priority_picker #(.N(N), .IW(IW)) u_picker (
        .i_req   (bus.i_Requests),
        .i_ptr   (ptr_q),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          others;

    // Held at zero while idle so every new grant starts a fresh count.
    always_comb begin
        cnt_d = '0;
        if (state_q == GRANT) cnt_d = (cnt_q == MAXC) ? cnt_q : cnt_q + 1'b1;
    end

    assign others       = |(bus.i_Requests & ~grants_q);
    assign hold_expired = (state_q == GRANT) && (cnt_d == MAXC) && others;
`else
    localparam int unused_max_hold = MAX_HOLD;
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    idx_d    = pick_idx;
                    grants_d = N'(1) << pick_idx;
                end
            end
            GRANT: begin
                if (!bus.i_Requests[idx_q] || hold_expired) begin
                    state_d  = IDLE;
                    grants_d = '0;
                    ptr_d    = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grants_q <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Write enable wins over read enable on the shared port.
    always_comb begin
        bus.o_Memory_Address      = '0;
        bus.o_Memory_Write_Data   = '0;
        bus.o_Memory_Write_Enable = 1'b0;
        bus.o_Memory_Read_Enable  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (state_q == GRANT && idx_q == IW'(k)) begin
                bus.o_Memory_Address      = bus.i_Proc_Address[k*AW +: AW];
                bus.o_Memory_Write_Data   = bus.i_Proc_Write_Data[k*DW +: DW];
                bus.o_Memory_Write_Enable = bus.i_Proc_Write_Enable[k];
                bus.o_Memory_Read_Enable  = bus.i_Proc_Read_Enable[k]
                                          & ~bus.i_Proc_Write_Enable[k];
            end
        end
    end

    assign bus.o_Grants         = grants_q;
    assign bus.o_Busy           = (state_q == GRANT);
    assign bus.o_Proc_Read_Data = bus.i_Memory_Read_Data;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: directed plan steps plus
// randomized traffic against an owner/pointer reference model.
module tb_memory_bus_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MH = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   ncmp  = 0;
    int   nfail = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    memory_bus_arbiter_if #(
        .NUMBER_OF_PROCESSORS(N), .WORD_SIZE(DW), .ADDRESS_WIDTH(AW)
    ) bus ();

    memory_bus_arbiter #(
        .NUMBER_OF_PROCESSORS(N), .WORD_SIZE(DW),
        .ADDRESS_WIDTH(AW), .MAX_HOLD(MH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: who owns the bus, and where the round-robin search starts.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && bus.i_Requests[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_cnt   = 0;
                end
            end
        end else begin
            m_cnt = (m_cnt < MH) ? m_cnt + 1 : MH;
            if (!bus.i_Requests[m_owner] ||
                (HOLD_EN && m_cnt == MH &&
                 (bus.i_Requests & ~(4'b0001 << m_owner)) != 4'b0000)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        logic [N-1:0]  g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
        logic          re;
        g  = '0;
        a  = '0;
        d  = '0;
        we = 1'b0;
        re = 1'b0;
        if (m_owner >= 0) begin
            g  = 4'b0001 << m_owner;
            a  = bus.i_Proc_Address[m_owner*AW +: AW];
            d  = bus.i_Proc_Write_Data[m_owner*DW +: DW];
            we = bus.i_Proc_Write_Enable[m_owner];
            re = bus.i_Proc_Read_Enable[m_owner] && !we;
        end
        chk({tag, ":grants"}, bus.o_Grants, g);
        chk({tag, ":busy"}, bus.o_Busy, m_owner >= 0);
        chk({tag, ":addr"}, bus.o_Memory_Address, a);
        chk({tag, ":wdata"}, bus.o_Memory_Write_Data, d);
        chk({tag, ":we"}, bus.o_Memory_Write_Enable, we);
        chk({tag, ":re"}, bus.o_Memory_Read_Enable, re);
        chk({tag, ":rdata"}, bus.o_Proc_Read_Data, bus.i_Memory_Read_Data);
    endtask

    task automatic cycle(string tag);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic set_slice(int k, logic [AW-1:0] a, logic [DW-1:0] d,
                             logic re, logic we);
        bus.i_Proc_Address[k*AW +: AW]    = a;
        bus.i_Proc_Write_Data[k*DW +: DW] = d;
        bus.i_Proc_Read_Enable[k]         = re;
        bus.i_Proc_Write_Enable[k]        = we;
    endtask

    initial begin
        bus.i_Requests          = '0;
        bus.i_Proc_Address      = '0;
        bus.i_Proc_Write_Data   = '0;
        bus.i_Proc_Read_Enable  = '0;
        bus.i_Proc_Write_Enable = '0;
        bus.i_Memory_Read_Data  = 32'h1234_5678;
        #1 reset = 1'b0;
        #1;
        chk("rst_grants", bus.o_Grants, 4'b0000);
        chk("rst_busy", bus.o_Busy, 1'b0);
        chk("rst_addr", bus.o_Memory_Address, '0);
        chk("rst_we", bus.o_Memory_Write_Enable, 1'b0);
        cycle("rst");
        cycle("rst");
        reset = 1'b1;

        // Single requester P2 writing
        set_slice(2, 10'h05A, 32'hDEADBEEF, 1'b0, 1'b1);
        bus.i_Requests = 4'b0100;
        cycle("t1");
        chk("t1_grant", bus.o_Grants, 4'b0100);
        chk("t1_addr", bus.o_Memory_Address, 10'h05A);
        chk("t1_wdata", bus.o_Memory_Write_Data, 32'hDEADBEEF);
        chk("t1_we", bus.o_Memory_Write_Enable, 1'b1);
        bus.i_Requests = 4'b0000;
        cycle("t1r");
        chk("t1_release", bus.o_Grants, 4'b0000);
        chk("t1_we_off", bus.o_Memory_Write_Enable, 1'b0);

        // All four together after reset, 3 cycles each
        reset = 1'b0;
        cycle("t2rst");
        reset = 1'b1;
        bus.i_Requests = 4'b1111;
        for (int p = 0; p < N; p++) begin
            cycle("t2");
            chk("t2_order", bus.o_Grants, 4'b0001 << p);
            cycle("t2");
            cycle("t2");
            chk("t2_hold", bus.o_Grants, 4'b0001 << p);
            bus.i_Requests[p] = 1'b0;
            cycle("t2b");
            chk("t2_bubble", bus.o_Grants, 4'b0000);
            chk("t2_bubble_busy", bus.o_Busy, 1'b0);
        end

        // Fairness: P0 drops one cycle while P1 waits
        bus.i_Requests = 4'b0011;
        cycle("t3");
        chk("t3_p0", bus.o_Grants, 4'b0001);
        bus.i_Requests[0] = 1'b0;
        cycle("t3");
        bus.i_Requests[0] = 1'b1;
        cycle("t3");
        chk("t3_p1_first", bus.o_Grants, 4'b0010);
        bus.i_Requests[1] = 1'b0;
        cycle("t3");
        cycle("t3");
        chk("t3_p0_after", bus.o_Grants, 4'b0001);
        bus.i_Requests = 4'b0000;
        cycle("t3");

        // Write beats read; non-granted enables ignored
        set_slice(1, 10'h111, 32'hA5A5_0001, 1'b1, 1'b1);
        set_slice(3, 10'h333, 32'hC3C3_0003, 1'b1, 1'b1);
        bus.i_Requests = 4'b0010;
        cycle("t4");
        chk("t4_we", bus.o_Memory_Write_Enable, 1'b1);
        chk("t4_re", bus.o_Memory_Read_Enable, 1'b0);
        chk("t4_addr", bus.o_Memory_Address, 10'h111);
        bus.i_Proc_Write_Enable[1] = 1'b0;
        cycle("t4");
        chk("t4_re_only", bus.o_Memory_Read_Enable, 1'b1);
        chk("t4_p3_ignored", bus.o_Memory_Write_Enable, 1'b0);
        bus.i_Proc_Read_Enable[1] = 1'b0;
        cycle("t4");
        chk("t4_none_re", bus.o_Memory_Read_Enable, 1'b0);
        bus.i_Requests = 4'b0000;
        cycle("t4");

        // Async reset while P3 holds the bus
        set_slice(3, 10'h3F0, 32'h0BAD_F00D, 1'b0, 1'b1);
        bus.i_Requests = 4'b1000;
        cycle("t5");
        chk("t5_p3", bus.o_Grants, 4'b1000);
        chk("t5_we", bus.o_Memory_Write_Enable, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_grants", bus.o_Grants, 4'b0000);
        chk("t5_async_we", bus.o_Memory_Write_Enable, 1'b0);
        chk("t5_async_busy", bus.o_Busy, 1'b0);
        bus.i_Requests = 4'b1001;
        cycle("t5r");
        cycle("t5r");
        reset = 1'b1;
        cycle("t5");
        chk("t5_p0_first", bus.o_Grants, 4'b0001);
        bus.i_Requests = 4'b0000;
        cycle("t5");

        // Hold timeout under contention
        bus.i_Proc_Read_Enable  = '0;
        bus.i_Proc_Write_Enable = '0;
        bus.i_Requests = 4'b0001;
        cycle("t6");
        chk("t6_p0", bus.o_Grants, 4'b0001);
        bus.i_Requests = 4'b0101;
`ifdef ARB_HOLD_TIMEOUT_EN
        for (int c = 0; c < MH - 1; c++) begin
            cycle("t6");
            chk("t6_held", bus.o_Grants, 4'b0001);
        end
        cycle("t6");
        chk("t6_revoked", bus.o_Grants, 4'b0000);
        cycle("t6");
        chk("t6_p2", bus.o_Grants, 4'b0100);
`else
        for (int c = 0; c < 2 * MH; c++) begin
            cycle("t6");
            chk("t6_kept", bus.o_Grants, 4'b0001);
        end
        bus.i_Requests = 4'b0100;
        cycle("t6");
        chk("t6_bubble", bus.o_Grants, 4'b0000);
        cycle("t6");
        chk("t6_p2", bus.o_Grants, 4'b0100);
`endif
        bus.i_Requests = 4'b0000;
        cycle("t6");
        cycle("t6");

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) bus.i_Requests[k] = ~bus.i_Requests[k];
            end
            bus.i_Proc_Address      = 40'({$urandom, $urandom});
            bus.i_Proc_Write_Data   = {$urandom, $urandom, $urandom, $urandom};
            bus.i_Proc_Read_Enable  = 4'($urandom);
            bus.i_Proc_Write_Enable = 4'($urandom);
            bus.i_Memory_Read_Data  = $urandom;
            reset = ($urandom_range(0, 49) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
